jt10_adpcm_mix_interp: RTL
==========================

Name: jt10_adpcm_mix_interp

Overview:
- Parametrised successor to the 6-channel ADPCM accumulator.
- Sums CH serially delivered channel samples per frame, with per-channel mute.
- Upsamples the frame sum by 2**RSH using linear interpolation, or zero-order hold when interpolation is off, then saturates to OW bits.
- Sits between the ADPCM decoder pipeline and the final FM/PCM mixer.

Parameters:
- CH, 6: number of channels per frame (2..16).
- IW, 16: input sample width, signed.
- OW, 16: output width, signed; OW <= IW+GUARD.
- GUARD, 3: accumulator guard bits; AW = IW+GUARD. GUARD < clog2(CH) is a compile-time error.
- RSH, 2: log2 of the upsampling ratio (ratio = 2**RSH), 0..4.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- cen, in, 1: clock enable; all state updates are qualified by cen.
- in_valid, in, 1: pcm_in/in_ch are valid this cen.
- in_ch, in, clog2(CH): channel index of pcm_in.
- in_last, in, 1: with in_valid, marks the final sample of the frame.
- pcm_in, in, IW: signed channel sample.
- ch_mute, in, CH: bit n set means channel n contributes 0.
- interp_en, in, 1: 1 selects linear interpolation, 0 selects hold.
- out_tick, in, 1: output-rate strobe, qualified by cen.
- pcm_out, out, OW: saturated interpolated sample.
- out_strobe, out, 1: one-clk pulse when pcm_out updates.

Behaviour:
- Reset: acc, cur, pos, step, cnt and pcm_out are 0; out_strobe is 0. Reset mid-frame discards the partial frame.
- Accumulate (cen & in_valid):
  - Add sign-extended pcm_in to acc, or add 0 if ch_mute[in_ch] is set.
  - in_ch >= CH: the sample is ignored, but in_last is still honoured.
  - Frames with missing channels are legal.
- Frame close (cen & in_valid & in_last), computed on sum = acc plus the current sample:
  - acc <= 0.
  - cur <= sum.
  - cnt <= 0.
  - interp_en=1: pos <= old cur; step <= (sum - old cur) >>> RSH (arithmetic, AW+1 bits).
  - interp_en=0: pos <= sum; step <= 0.
  - Interpolation therefore lags one frame; pos ramps from the previous sum toward the new one.
- Out tick (cen & out_tick):
  - pcm_out <= sat(pos) using the pre-update pos.
  - out_strobe pulses for 1 clk.
  - Then, if cnt < 2**RSH-1: pos <= pos+step and cnt++. Otherwise pos holds.
  - Latency: pcm_out is valid 1 clk after the tick.
- Simultaneous frame close and out tick: pcm_out takes sat(old pos); the frame-close reload of pos, cnt and step wins over the increment.
- Saturation: if pos > 2**(OW-1)-1, output 2**(OW-1)-1. If pos < -2**(OW-1), output -2**(OW-1). Otherwise output pos[OW-1:0].
- RSH=0: cnt limit is 0, so pos never increments (pure hold of the previous frame sum when interpolating).
- A change of interp_en takes effect at the next frame close only.

Optional Feature:
- Macro JT10_MIX_PEAK_EN.
- Defined:
  - Adds input peak_clr (1 bit) and output peak_out (OW bits, unsigned magnitude).
  - On each out tick, peak_out <= max(peak_out, |sat(pos)|), with |-2**(OW-1)| clamped to 2**(OW-1)-1.
  - peak_clr & cen zeroes peak_out; if a tick occurs in the same cycle, peak_out instead loads the current |sample|.
  - Reset value of peak_out is 0.
- Undefined: no extra ports or logic.

Test Plan:
- Reset: assert rst_n=0 mid-frame, then release -> pcm_out=0, out_strobe=0; the next full frame is summed from 0.
- CH=6, RSH=2, interp_en=1, six samples of 1000, in_last on the 6th, then 5 out ticks -> pcm_out = 0, 1500, 3000, 4500, 4500. On the next frame close (all 0), pos=6000 and step=-1500.
- Saturation, interp_en=0:
  - Six samples of 0x7FFF, close, tick -> pcm_out=0x7FFF.
  - Six samples of 0x8000 -> pcm_out=0x8000.
  - Samples 0x4000, 0xC000 (sum 0) -> pcm_out=0.
- Mute and invalid index: ch_mute=6'b000010, samples 100 on ch0..5 plus one sample with in_ch=7 -> sum 500; with interp_en=0 the tick gives pcm_out=500.
- Collision: frame close and out tick in the same cen with pos=3000 -> pcm_out=3000; pos is reloaded to old cur and cnt=0.
- JT10_MIX_PEAK_EN:
  - Outputs 4500, then -7000 -> peak_out=7000.
  - peak_clr -> 0.
  - Output 0x8000 -> peak_out=0x7FFF.

Source files
------------

// File: rtl/jt10_adpcm_mix_interp.sv
`default_nettype none
// ============================================================================
// Module   : jt10_adpcm_mix_interp
// Purpose  : Sums CH serially delivered ADPCM channel samples per frame with
//            per-channel mute. The frame sum is upsampled by 2**RSH using
//            linear interpolation, or zero-order hold when interpolation is
//            off. The upsampled value is saturated to OW bits.
// Option   : define JT10_MIX_PEAK_EN to add a peak-magnitude meter
//            (peak_clr / peak_out).
// Revision : 1.0 - initial parametrised release
// ============================================================================
module jt10_adpcm_mix_interp #(
  parameter int CH    = 6,
  parameter int IW    = 16,
  parameter int OW    = 16,
  parameter int GUARD = 3,
  parameter int RSH   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cen,
  input  logic                    in_valid,
  input  logic [$clog2(CH)-1:0]   in_ch,
  input  logic                    in_last,
  input  logic [IW-1:0]           pcm_in,
  input  logic [CH-1:0]           ch_mute,
  input  logic                    interp_en,
  input  logic                    out_tick,
`ifdef JT10_MIX_PEAK_EN
  input  logic                    peak_clr,
  output logic [OW-1:0]           peak_out,
`endif
  output logic [OW-1:0]           pcm_out,
  output logic                    out_strobe
);

  localparam int AW   = IW + GUARD;
  localparam int CW   = $clog2(CH);
  localparam int CNTW = (RSH > 0) ? RSH : 1;
  localparam logic [CNTW-1:0] CNT_LIM = CNTW'((1 << RSH) - 1);
  // Saturation limits expressed at the interpolator width
  localparam logic signed [AW:0] SAT_MAX = {{(AW-OW+2){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW:0] SAT_MIN = ~SAT_MAX;

  // Parameter sanity checks, resolved at elaboration
  if (GUARD < CW) begin : g_bad_guard
    $error("jt10_adpcm_mix_interp: GUARD must be >= clog2(CH)");
  end
  if (OW > AW) begin : g_bad_ow
    $error("jt10_adpcm_mix_interp: OW must be <= IW+GUARD");
  end
  if (CH < 2 || CH > 16) begin : g_bad_ch
    $error("jt10_adpcm_mix_interp: CH must be in 2..16");
  end
  if (RSH < 0 || RSH > 4) begin : g_bad_rsh
    $error("jt10_adpcm_mix_interp: RSH must be in 0..4");
  end

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] cur;
  logic signed [AW:0]   pos;
  logic signed [AW:0]   step;
  logic [CNTW-1:0]      cnt;

  logic                 ch_ok;
  logic                 use_sample;
  logic                 frame_close;
  logic                 tick;
  logic signed [AW-1:0] sample_ext;
  logic signed [AW-1:0] sum;
  logic signed [AW:0]   diff;
  logic [OW-1:0]        sat_val;

  // Sample qualification: out-of-range indices and muted channels add nothing
  always_comb begin
    ch_ok       = ({1'b0, in_ch} < (CW+1)'(CH));
    use_sample  = ch_ok && !ch_mute[in_ch];
    sample_ext  = {{GUARD{pcm_in[IW-1]}}, pcm_in};
    sum         = acc + (use_sample ? sample_ext : '0);
    diff        = {sum[AW-1], sum} - {cur[AW-1], cur};
    frame_close = cen & in_valid & in_last;
    tick        = cen & out_tick;
  end

  // Clamp the current interpolator position to the output range
  always_comb begin
    sat_val = pos[OW-1:0];
    if (pos > SAT_MAX) begin
      sat_val = SAT_MAX[OW-1:0];
    end else if (pos < SAT_MIN) begin
      sat_val = SAT_MIN[OW-1:0];
    end
  end

  // Frame accumulator; the closing sample lands in cur and acc restarts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cur <= '0;
    end else if (cen && in_valid) begin
      if (in_last) begin
        acc <= '0;
        cur <= sum;
      end else begin
        acc <= sum;
      end
    end
  end

  // Interpolator: a frame close reloads the ramp and wins over a tick step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos  <= '0;
      step <= '0;
      cnt  <= '0;
    end else if (frame_close) begin
      cnt <= '0;
      if (interp_en) begin
        pos  <= {cur[AW-1], cur};
        step <= diff >>> RSH;
      end else begin
        pos  <= {sum[AW-1], sum};
        step <= '0;
      end
    end else if (tick && (cnt < CNT_LIM)) begin
      pos <= pos + step;
      cnt <= cnt + CNTW'(1);
    end
  end

  // Output register: present the pre-update position on every tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcm_out    <= '0;
      out_strobe <= 1'b0;
    end else begin
      out_strobe <= tick;
      if (tick) begin
        pcm_out <= sat_val;
      end
    end
  end

`ifdef JT10_MIX_PEAK_EN
  logic [OW-1:0] sat_abs;

  // Magnitude of the outgoing sample; the most negative code folds to max
  always_comb begin
    if (sat_val == SAT_MIN[OW-1:0]) begin
      sat_abs = SAT_MAX[OW-1:0];
    end else if (sat_val[OW-1]) begin
      sat_abs = OW'(-sat_val);
    end else begin
      sat_abs = sat_val;
    end
  end

  // Peak meter; a clear coinciding with a tick restarts from this sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_out <= '0;
    end else if (cen) begin
      if (out_tick) begin
        if (peak_clr || (sat_abs > peak_out)) begin
          peak_out <= sat_abs;
        end
      end else if (peak_clr) begin
        peak_out <= '0;
      end
    end
  end
`endif

endmodule
`default_nettype wire
